// File: rtl/led_game_controller.sv
// led_game_controller: reaction-game round sequencer; optional LED_CTRL_SPEEDUP_EN shortens the window as score grows
module led_game_controller #(
  parameter int NUM_LEDS      = 10,
  parameter int WINDOW_TICKS  = 3,
  parameter int MAX_MISSES    = 3,
  parameter int SCORE_W       = 8,
  parameter int SPEEDUP_EVERY = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic                start,
  input  logic [NUM_LEDS-1:0] hit,
  input  logic [3:0]          rng_value,
  output logic                rng_step,
  output logic [3:0]          led_number,
  output logic                led_valid,
  output logic [SCORE_W-1:0]  score,
  output logic [3:0]          misses,
  output logic                game_over
);
  localparam int CW = $clog2(WINDOW_TICKS + 1);
  typedef enum logic [2:0] {IDLE, DRAW_REQ, DRAW_CHK, SHOW, RESULT, OVER} state_t;
  state_t state, state_nxt;
  logic [NUM_LEDS-1:0] hit_q, rise, tgt_mask;
  logic [CW-1:0] cnt, cnt_nxt, win;
  logic [3:0] led_nxt, misses_nxt;
  logic [SCORE_W-1:0] score_nxt, score_inc;
  logic wrong, right, draw_ok;
  assign rise      = hit & ~hit_q;
  assign tgt_mask  = NUM_LEDS'(1) << led_number;
  assign wrong     = |(rise & ~tgt_mask);
  assign right     = |(rise & tgt_mask);
  assign draw_ok   = {1'b0, rng_value} < 5'(NUM_LEDS);
  assign score_inc = (score == '1) ? score : score + 1'b1;
`ifdef LED_CTRL_SPEEDUP_EN
  logic [SCORE_W-1:0] cut;
  assign cut = score / SCORE_W'(SPEEDUP_EVERY);
  assign win = (32'(cut) < 32'(WINDOW_TICKS)) ? CW'(32'(WINDOW_TICKS) - 32'(cut)) : CW'(1);
`else
  assign win = CW'(WINDOW_TICKS);
`endif
  // State, key edge history, drawn LED, remaining window and tallies
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hit_q      <= '0;
      led_number <= '0;
      cnt        <= '0;
      score      <= '0;
      misses     <= '0;
    end else begin
      state      <= state_nxt;
      hit_q      <= hit;
      led_number <= led_nxt;
      cnt        <= cnt_nxt;
      score      <= score_nxt;
      misses     <= misses_nxt;
    end
  end
  // Round sequencing: draw, show with window, judge wrong/right/timeout, wait for release
  always_comb begin
    state_nxt  = state;
    led_nxt    = led_number;
    cnt_nxt    = cnt;
    score_nxt  = score;
    misses_nxt = misses;
    rng_step   = 1'b0;
    led_valid  = 1'b0;
    game_over  = 1'b0;
    case (state)
      IDLE, OVER: begin
        game_over = state == OVER;
        if (start) begin
          state_nxt  = DRAW_REQ;
          score_nxt  = '0;
          misses_nxt = '0;
        end
      end
      DRAW_REQ: begin
        rng_step  = 1'b1;
        state_nxt = DRAW_CHK;
      end
      DRAW_CHK: begin
        state_nxt = draw_ok ? SHOW : DRAW_REQ;
        led_nxt   = draw_ok ? rng_value : led_number;
        cnt_nxt   = draw_ok ? win : cnt;
      end
      SHOW: begin
        led_valid = 1'b1;
        if (wrong || (tick && cnt == CW'(1) && !right)) begin
          misses_nxt = misses + 1'b1;
          state_nxt  = RESULT;
        end else if (right) begin
          score_nxt = score_inc;
          state_nxt = RESULT;
        end else if (tick) begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RESULT: if (hit == '0) state_nxt = (misses == 4'(MAX_MISSES)) ? OVER : DRAW_REQ;
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_led_game_controller.sv
// tb_led_game_controller: table rows, hand sequences and random rounds against a round-level score/miss model
module tb_led_game_controller;
  localparam int N = 10;
  localparam int MAXM = 3;
  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, start = 1'b0;
  logic [N-1:0] hit = '0;
  logic [3:0] rng_value = '0;
  logic rng_step, led_valid, game_over;
  logic [3:0] led_number, misses;
  logic [7:0] score;
  int total = 0, bad = 0;
  int m_score = 0, m_miss = 0;

  typedef struct {int kind; int tgt; int redraws; int exp_score; int exp_miss;} vec_t;
  vec_t tbl[6];

  always #10 clk = ~clk;

  led_game_controller dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .hit(hit),
    .rng_value(rng_value), .rng_step(rng_step), .led_number(led_number),
    .led_valid(led_valid), .score(score), .misses(misses), .game_over(game_over)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int win();
`ifdef LED_CTRL_SPEEDUP_EN
    return (3 - m_score / 4) < 1 ? 1 : 3 - m_score / 4;
`else
    return 3;
`endif
  endfunction

  // Called while rng_step is high; serves some out-of-range values then the target
  task automatic draw(input int tgt, input int redraws);
    for (int i = 0; i < redraws; i++) begin
      rng_value = 4'(10 + int'($urandom_range(5)));
      cyc();
      chk("redraw_dark", led_valid, 0);
      chk("redraw_chk_nostep", rng_step, 0);
      cyc();
      chk("redraw_step", rng_step, 1);
    end
    rng_value = 4'(tgt);
    cyc();
    chk("chk_dark", led_valid, 0);
    cyc();
    chk("led_valid", led_valid, 1);
    chk("led_number", led_number, tgt);
  endtask

  // kind: 0 clean hit, 1 wrong key, 2 timeout, 3 hit on the expiring tick
  task automatic round(input int kind, input int tgt);
    int w, k, other, hold;
    logic [N-1:0] keys;
    w = win();
    k = (kind == 2) ? w : (kind == 3) ? w - 1 : int'($urandom_range(w - 1));
    for (int i = 0; i < k; i++) begin
      chk("lit_in_window", led_valid, 1);
      tick = 1'b1;
      cyc();
      tick = 1'b0;
    end
    if (kind != 2) begin
      other = (tgt + 1 + int'($urandom_range(N - 2))) % N;
      keys = N'(1) << tgt;
      if (kind == 1) keys = ($urandom_range(1) == 1) ? (keys | (N'(1) << other)) : (N'(1) << other);
      hit = keys;
      tick = (kind == 3);
      cyc();
      tick = 1'b0;
    end
    if (kind == 1 || kind == 2) m_miss++;
    else if (m_score < 255) m_score++;
    chk("result_dark", led_valid, 0);
    chk("led_hold", led_number, tgt);
    chk("score", score, m_score);
    chk("misses", misses, m_miss);
    hold = (kind == 2) ? 0 : int'($urandom_range(3));
    for (int i = 0; i < hold; i++) begin
      start = 1'($urandom_range(1));
      tick = 1'($urandom_range(1));
      cyc();
      start = 1'b0;
      tick = 1'b0;
      chk("held_no_step", rng_step, 0);
      chk("held_score", score, m_score);
    end
    hit = '0;
    cyc();
    if (m_miss == MAXM) chk("over", game_over, 1);
    else chk("next_step", rng_step, 1);
  endtask

  task automatic restart();
    chk("over_flag", game_over, 1);
    tick = 1'b1;
    repeat (2) cyc();
    tick = 1'b0;
    chk("over_score_held", score, m_score);
    chk("over_misses_held", misses, m_miss);
    chk("over_dark", led_valid, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    m_score = 0;
    m_miss = 0;
    chk("restart_step", rng_step, 1);
    chk("restart_score", score, 0);
    chk("restart_misses", misses, 0);
    chk("restart_over", game_over, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end after %0d checks want finish", total);
    $fatal(1);
  end

  initial begin
    int t;
    tbl[0] = '{0, 3, 1, 2, 0};
    tbl[1] = '{1, 5, 0, 2, 1};
    tbl[2] = '{3, 5, 0, 3, 1};
    tbl[3] = '{2, 0, 2, 3, 2};
    tbl[4] = '{0, 9, 0, 4, 2};
    tbl[5] = '{2, 4, 0, 4, 3};
    #25;
    chk("rst_valid", led_valid, 0);
    chk("rst_step", rng_step, 0);
    chk("rst_over", game_over, 0);
    chk("rst_score", score, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick = 1'b1;
    cyc();
    cyc();
    tick = 1'b0;
    chk("idle_no_step", rng_step, 0);
    chk("idle_dark", led_valid, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("start_to_step", rng_step, 1);
    rng_value = 4'd7;
    cyc();
    chk("step_one_cycle", rng_step, 0);
    chk("step_dark", led_valid, 0);
    cyc();
    chk("show7_valid", led_valid, 1);
    chk("show7_number", led_number, 7);
    hit = N'(1) << 7;
    cyc();
    chk("hit7_score", score, 1);
    chk("hit7_dark", led_valid, 0);
    hit = '0;
    cyc();
    chk("hit7_next_step", rng_step, 1);
    m_score = 1;
    for (int i = 0; i < 6; i++) begin
      draw(tbl[i].tgt, tbl[i].redraws);
      round(tbl[i].kind, tbl[i].tgt);
      chk("tbl_score", score, tbl[i].exp_score);
      chk("tbl_misses", misses, tbl[i].exp_miss);
    end
    restart();
    hit = N'(1) << 5;
    rng_value = 4'd5;
    cyc();
    cyc();
    chk("prehold_show", led_valid, 1);
    cyc();
    chk("prehold_no_judge", led_valid, 1);
    hit = '0;
    cyc();
    chk("release_no_judge", led_valid, 1);
    hit = (N'(1) << 5) | (N'(1) << 2);
    cyc();
    chk("dual_rise_miss", misses, 1);
    chk("dual_rise_no_score", score, 0);
    hit = N'(1) << 5;
    cyc();
    cyc();
    chk("held_target_wait", rng_step, 0);
    chk("held_target_no_score", score, 0);
    hit = '0;
    cyc();
    chk("dual_next_step", rng_step, 1);
    m_miss = 1;
    for (int i = 0; i < 8; i++) begin
      draw(i, 0);
      round(0, i);
    end
    chk("score8", score, 8);
    draw(2, 0);
    tick = 1'b1;
    cyc();
`ifdef LED_CTRL_SPEEDUP_EN
    tick = 1'b0;
    chk("speedup_1tick_miss", misses, m_miss + 1);
`else
    chk("no_early_timeout", led_valid, 1);
    cyc();
    chk("no_early_timeout2", led_valid, 1);
    cyc();
    tick = 1'b0;
    chk("full_window_miss", misses, m_miss + 1);
`endif
    m_miss++;
    chk("timeout_dark", led_valid, 0);
    cyc();
    chk("timeout_next_step", rng_step, 1);
    draw(4, 0);
    #2 rst_n = 1'b0;
    #2;
    chk("async_rst_valid", led_valid, 0);
    chk("async_rst_step", rng_step, 0);
    chk("async_rst_over", game_over, 0);
    chk("async_rst_score", score, 0);
    chk("async_rst_misses", misses, 0);
    chk("async_rst_number", led_number, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("post_rst_idle", rng_step, 0);
    chk("post_rst_dark", led_valid, 0);
    m_score = 0;
    m_miss = 0;
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("post_rst_start", rng_step, 1);
    for (int r = 0; r < 60; r++) begin
      t = int'($urandom_range(N - 1));
      draw(t, int'($urandom_range(2)));
      round(int'($urandom_range(3)), t);
      if (m_miss == MAXM) restart();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
